shacc_ctrl: RTL
===============

SHACC_CTRL -- requirements
Module: shacc_ctrl

Interface
REQ-001 Parameter PW, default 4: width of the bit-plane count input prec; up to 2^PW-1 planes.
REQ-002 Parameter LW, default 16: width of the chunks-per-plane input len.
REQ-003 clk  in  1  single clock; every register updates on the rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  job request; sampled only while start_ready=1.
REQ-006 start_ready  out  1  high in IDLE only.
REQ-007 prec  in  PW  bit-planes per job, MSB plane first; latched on start acceptance.
REQ-008 len  in  LW  partial-sum beats per plane; latched on start acceptance.
REQ-009 in_valid  in  1  upstream partial sum present on the shifter-accumulator I port this cycle.
REQ-010 in_ready  out  1  high in RUN only; a beat transfers when in_valid=1 and in_ready=1.
REQ-011 abort  in  1  cancels the current job in RUN or DONE.
REQ-012 acc_clr, acc_load, acc_acc, acc_sh  out  1 each  drive the clr, load, acc and sh ports of the shifter-accumulator.
REQ-013 out_valid  out  1  accumulator output O holds the final job result.
REQ-014 out_ready  in  1  consumer accepts the result.

Function
REQ-015 States: IDLE, RUN, DONE, encoded as a registered 2-bit state.
REQ-016 IDLE->RUN when start=1, prec!=0 and len!=0; the same edge latches prec and len and zeroes the plane counter p and the chunk counter c.
REQ-017 A start with prec=0 or len=0 is ignored: the block stays in IDLE and all outputs remain 0.
REQ-018 In RUN, a beat at p=0, c=0 asserts acc_load=1, acc_acc=0, acc_sh=0.
REQ-019 In RUN, a beat at p>0, c=0 asserts acc_acc=1, acc_sh=1 (accumulator shifts left, then adds).
REQ-020 In RUN, a beat at c>0 asserts acc_acc=1, acc_sh=0 (plain accumulate).
REQ-021 acc_load, acc_acc and acc_sh are combinational from state, p, c and in_valid, and are 0 in any cycle with no beat; counters hold on in_valid=0.
REQ-022 Each beat increments c; at c=len-1, c wraps to 0 and p increments.
REQ-023 The beat at p=prec-1, c=len-1 moves the block RUN->DONE; a job therefore takes exactly prec*len beats.
REQ-024 In DONE, out_valid=1 and all accumulator controls are 0; O is valid in the first DONE cycle (one-edge latency after the last beat).
REQ-025 DONE->IDLE on out_valid and out_ready; out_valid holds while out_ready=0.
REQ-026 abort=1 in RUN or DONE forces acc_clr=1 combinationally for that cycle, moves to IDLE, and takes priority over a simultaneous beat or out_ready.
REQ-027 abort in IDLE has no effect, and acc_clr=0.
REQ-028 start is ignored outside IDLE; DONE never goes directly to RUN.
REQ-029 A start arriving in the same cycle as DONE->IDLE is not accepted, because start_ready is still 0 in that cycle.

Reset
REQ-030 While clr=1: state=IDLE, p=0, c=0, latched prec=0, latched len=0.
REQ-031 While clr=1, every output except start_ready is 0 and start_ready=1.
REQ-032 clr asserted mid-job discards the job with no out_valid pulse; the accumulator is reset separately by the system clr.

Structure
REQ-033 Package shacc_pkg holds the state enum (IDLE, RUN, DONE) and the default PW and LW constants.
REQ-034 No sub-module: both counters and the FSM are inline, and the shifter-accumulator is instantiated by the parent alongside this block.

Verification
REQ-035 prec=3, len=1, beats I=1,0,1 back-to-back -> controls load / acc+sh / acc+sh, O=5, out_valid on the cycle after the third beat.
REQ-036 prec=2, len=2, beats 1,2,3,4 with in_valid low on alternate cycles -> O=((1+2)*2)+3+4=13, counters frozen during gaps, exactly 4 beats.
REQ-037 Job done with out_ready=0 for 5 cycles -> out_valid and O stable for all 5 cycles; IDLE one edge after out_ready=1.
REQ-038 abort during the 2nd beat of prec=2, len=2 -> acc_clr=1 that cycle, no load/acc pulse, IDLE next edge, O=0, start_ready=1.
REQ-039 start with len=0, then clr pulsed mid-RUN of a prec=4 job -> first start ignored; after clr: IDLE, all outputs 0, no out_valid.
REQ-040 prec=1, len=1 single beat I=-4 -> acc_load only, O=-4, DONE after 1 beat.

Source files
------------

// File: rtl/shacc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shacc_pkg
// Description : Shared state encoding and default widths for shacc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package shacc_pkg;

    localparam int c_default_pw = 4;
    localparam int c_default_lw = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shacc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shacc_ctrl
// Description : Bit-serial job sequencer driving an external shifter-
//               accumulator (MSB plane first, len beats per plane).
// Revision    : 1.0 - initial release
// ============================================================================
module shacc_ctrl
    import shacc_pkg::*;
#(
    parameter int PW = c_default_pw,
    parameter int LW = c_default_lw
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    output logic          start_ready,
    input  logic [PW-1:0] prec,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          acc_clr,
    output logic          acc_load,
    output logic          acc_acc,
    output logic          acc_sh,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_p;
    logic [PW-1:0] w_p_nxt;
    logic [PW-1:0] r_prec;
    logic [PW-1:0] w_prec_nxt;
    logic [LW-1:0] r_c;
    logic [LW-1:0] w_c_nxt;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len_nxt;
    logic          w_first_chunk;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_c     <= '0;
            r_prec  <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_c     <= w_c_nxt;
            r_prec  <= w_prec_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_p_nxt       = r_p;
        w_c_nxt       = r_c;
        w_prec_nxt    = r_prec;
        w_len_nxt     = r_len;
        w_first_chunk = (r_c == '0);
        start_ready   = 1'b0;
        in_ready      = 1'b0;
        acc_clr       = 1'b0;
        acc_load      = 1'b0;
        acc_acc       = 1'b0;
        acc_sh        = 1'b0;
        out_valid     = 1'b0;

        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                // Zero-sized jobs would never produce a beat, so they are dropped here.
                if (start && (prec != '0) && (len != '0)) begin
                    w_state_nxt = RUN;
                    w_p_nxt     = '0;
                    w_c_nxt     = '0;
                    w_prec_nxt  = prec;
                    w_len_nxt   = len;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (abort) begin
                    acc_clr     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (in_valid) begin
                    // First beat of each later plane shifts the running sum one bit up.
                    acc_load = (r_p == '0) && w_first_chunk;
                    acc_acc  = !((r_p == '0) && w_first_chunk);
                    acc_sh   = w_first_chunk && (r_p != '0);
                    if (r_c == r_len - LW'(1)) begin
                        w_c_nxt = '0;
                        w_p_nxt = r_p + PW'(1);
                        if (r_p == r_prec - PW'(1)) begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_c_nxt = r_c + LW'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (abort) begin
                    acc_clr     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
